sonar_scan_ctrl: RTL

- Parametrised successor to the single-channel trig/echo measurement path.
- Drives CH_NUM ultrasonic sensors in round-robin sweeps and measures each echo pulse width in microseconds using the shared pluse_us tick.
- Reports per-channel results with channel ID, timeout error, single-shot and continuous modes.
- Sits between the sensor pins and the HMI/control logic; fire_measure typically comes from key_vld or the fx bus.

---
 rtl/sonar_scan_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sonar_scan_ctrl.sv
// Round-robin ultrasonic sweep controller: fires each enabled sensor in turn and
// measures the echo pulse width in pluse_us ticks, with timeout and continuous modes.
module sonar_scan_ctrl #(
    parameter int CH_NUM     = 4,
    parameter int CNT_W      = 16,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 1000,
    localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              pluse_us,
    input  logic              fire_measure,
    input  logic              mode_cont,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [CH_NUM-1:0] echo,
    output logic [CH_NUM-1:0] trig,
    output logic              busy,
    output logic              done_measure,
    output logic              err_measure,
    output logic [CH_W-1:0]   ch_id,
    output logic [CNT_W-1:0]  data_measure,
    output logic              sweep_done
);

    localparam logic [CNT_W-1:0] TRIG_LEN = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0] TMO_LEN  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEAS,
        GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [CH_W-1:0]   ch, ch_nxt, first_ch, next_ch;
    logic              has_next;
    logic [CH_NUM-1:0] mask_lat, mask_nxt;
    logic [CH_NUM-1:0] echo_s1, echo_s2, echo_d, echo_rise, echo_fall;
    logic              start_req, cont_req;
    logic              done_nxt, err_nxt, sweep_nxt;
    logic [CH_W-1:0]   id_nxt;
    logic [CNT_W-1:0]  data_nxt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    always_comb begin
        echo_rise = echo_s2 & ~echo_d;
        echo_fall = ~echo_s2 & echo_d;
    end

    // first_ch scans the live mask (sweep start); next_ch scans the latched mask above ch.
    always_comb begin
        logic found;
        found    = 1'b0;
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (ch_mask[i] && !found) begin
                first_ch = CH_W'(i);
                found    = 1'b1;
            end
            if (mask_lat[i] && !has_next && (CH_W'(i) > ch)) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        trig = '0;
        if (state == TRIG) begin
            trig[ch] = 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign cnt_inc = cnt + CNT_W'(pluse_us);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        mask_nxt  = mask_lat;
        done_nxt  = 1'b0;
        sweep_nxt = 1'b0;
        err_nxt   = err_measure;
        id_nxt    = ch_id;
        data_nxt  = data_measure;
        start_req = (fire_measure || mode_cont) && (ch_mask != '0);
        cont_req  = mode_cont && (ch_mask != '0);

        case (state)
            IDLE: begin
                if (start_req) begin
                    mask_nxt  = ch_mask;
                    ch_nxt    = first_ch;
                    cnt_nxt   = '0;
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == TRIG_LEN) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise[ch]) begin
                    cnt_nxt   = '0;
                    state_nxt = MEAS;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TMO_LEN) begin
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        id_nxt    = ch;
                        data_nxt  = TMO_LEN;
                        cnt_nxt   = '0;
                        state_nxt = GAP;
                    end
                end
            end
            MEAS: begin
                cnt_nxt = cnt_inc;
                // Saturation wins over a coincident fall so the count never passes TIMEOUT_US.
                if (cnt_inc == TMO_LEN) begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    id_nxt    = ch;
                    data_nxt  = TMO_LEN;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else if (echo_fall[ch]) begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                    id_nxt    = ch;
                    data_nxt  = cnt_inc;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == GAP_LEN) begin
                    cnt_nxt = '0;
                    if (has_next) begin
                        ch_nxt    = next_ch;
                        state_nxt = TRIG;
                    end else begin
                        sweep_nxt = 1'b1;
                        if (cont_req) begin
                            mask_nxt  = ch_mask;
                            ch_nxt    = first_ch;
                            state_nxt = TRIG;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ch           <= '0;
            mask_lat     <= '0;
            done_measure <= 1'b0;
            err_measure  <= 1'b0;
            ch_id        <= '0;
            data_measure <= '0;
            sweep_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ch           <= ch_nxt;
            mask_lat     <= mask_nxt;
            done_measure <= done_nxt;
            err_measure  <= err_nxt;
            ch_id        <= id_nxt;
            data_measure <= data_nxt;
            sweep_done   <= sweep_nxt;
        end
    end

endmodule
